wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Writeback stage plus architectural register file of the 5-stage MIPS pipeline.
//   Consumes the MEM/WB pipeline register outputs.
//   Selects the writeback result (memory read data or ALU result) and commits it to
//   the 32-entry register file.
//   Serves the two decode-stage read ports, with same-cycle write-to-read bypass.
// PARAMETERS
//   DATA_W   32   register/data width in bits
//   ADDR_W   5    register address width
//   NREGS    32   number of registers (2**ADDR_W); entry 0 hardwired to zero
//   BYPASS   1    1 = forward same-cycle write data to read ports; 0 = no bypass
// PORTS
//   ref_clk    in   1       pipeline clock; all state updates on rising edge
//   reset      in   1       asynchronous, active-high reset
//   RegWriteW  in   1       writeback enable from MEM/WB register
//   MemtoRegW  in   1       1 = result is rd_in (load data); 0 = result is alu_in
//   rd_in      in   DATA_W  memory read data from MEM/WB register
//   alu_in     in   DATA_W  ALU result from MEM/WB register
//   WriteRegW  in   ADDR_W  destination register number
//   A1         in   ADDR_W  decode read address, port 1 (rs)
//   A2         in   ADDR_W  decode read address, port 2 (rt)
//   RD1        out  DATA_W  read data, port 1
//   RD2        out  DATA_W  read data, port 2
//   ResultW    out  DATA_W  selected writeback value (fed to forwarding muxes)
// BEHAVIOUR
//   - ResultW is combinational: MemtoRegW ? rd_in : alu_in. No latency, no reset value.
//   - Write condition:
//       - Commit at posedge ref_clk when RegWriteW=1 and WriteRegW!=0 and reset=0.
//       - Entry[WriteRegW] <= ResultW; all other entries hold.
//   - Writes to register 0 are discarded; entry 0 always reads 0.
//   - Reads are combinational, evaluated in this priority order:
//       - If An==0, then RDn=0.
//       - Else if BYPASS=1 and RegWriteW=1 and WriteRegW==An and reset=0,
//         then RDn=ResultW (new value visible in the same cycle).
//       - Else RDn=entry[An].
//   - With BYPASS=0, a same-cycle read returns the old value; the new value is
//     visible from the cycle after the edge.
//   - A1==A2 is legal; both ports return identical data.
//   - Reset:
//       - reset=1 asynchronously clears entries 1..NREGS-1 to 0, without waiting
//         for a clock edge.
//       - While reset is high: no writes occur, bypass is suppressed, RD1=RD2=0.
//       - A write pending at the edge where reset rises is lost.
//       - First write after reset deasserts occurs on the next rising edge with
//         the write condition true.
//   - Registers remain in the state machine only as storage: NREGS-1 DATA_W flops;
//     no other sequential state.
// TESTING
//   1. Reset:
//        - reset=1 mid-run after entries were written -> RD1/RD2=0 for all A1/A2
//          immediately.
//        - After release, reads of regs 1..31 return 0.
//   2. ALU write:
//        - RegWriteW=1, MemtoRegW=0, alu_in=32'h0000_0003, WriteRegW=2; edge.
//        - A1=2 -> RD1=32'h3.
//        - ResultW=32'h3 before the edge.
//   3. Load write:
//        - RegWriteW=1, MemtoRegW=1, rd_in=32'h0000_00F8, alu_in=32'h700,
//          WriteRegW=3; edge.
//        - A2=3 -> RD2=32'hF8.
//   4. r0 protection:
//        - RegWriteW=1, WriteRegW=0, alu_in=32'hDEAD_BEEF; edge.
//        - A1=0 -> RD1=0.
//        - No other entry changes.
//   5. Bypass:
//        - Reg 6 holds 32'h1; drive RegWriteW=1, WriteRegW=6, alu_in=32'hF, A1=6.
//        - Before the edge: RD1=32'hF with BYPASS=1, RD1=32'h1 with BYPASS=0.
//        - After the edge: RD1=32'hF in both cases.
//   6. Write disabled:
//        - RegWriteW=0, WriteRegW=1, alu_in=32'h2; edge.
//        - A1=1 -> RD1 keeps its prior value.
//        - ResultW still equals 32'h2.

Source files
------------

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and architectural register file of the 5-stage MIPS
//   pipeline. The MEM/WB register outputs select the writeback result, which
//   is either the load data or the ALU result. That result is committed to a
//   32-entry register file, and entry 0 is hardwired to zero. Two
//   combinational read ports serve the decode stage. They can optionally
//   forward a write that happens in the same cycle.
//
// Handshake: none. Every input is sampled as a plain level. A write commits
//   on a rising ref_clk edge when RegWriteW=1, WriteRegW!=0 and reset=0.
//
// Parameters
//   DATA_W  register/data width
//   ADDR_W  register address width
//   NREGS   number of registers (2**ADDR_W), entry 0 reads as zero
//   BYPASS  1: the read ports see same-cycle write data; 0: they see the old value
//
// Ports
//   ref_clk    in   pipeline clock, rising-edge
//   reset      in   asynchronous active-high reset, clears entries 1..NREGS-1
//   RegWriteW  in   writeback enable
//   MemtoRegW  in   1 selects rd_in, 0 selects alu_in
//   rd_in      in   memory read data
//   alu_in     in   ALU result
//   WriteRegW  in   destination register number
//   A1, A2     in   read addresses (rs, rt)
//   RD1, RD2   out  read data
//   ResultW    out  selected writeback value (feeds forwarding muxes)
// ----------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic [DATA_W-1:0] rd_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] ResultW
);

    localparam bit BYPASS_EN = (BYPASS != 0);

    // Entry 0 has no storage. Only entries 1..NREGS-1 are flops.
    logic [DATA_W-1:0] regs_q [1:NREGS-1];

    logic write_en;

    assign ResultW  = MemtoRegW ? rd_in : alu_in;
    assign write_en = RegWriteW && (WriteRegW != '0) && !reset;

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_en) begin
            regs_q[WriteRegW] <= ResultW;
        end
    end

    // Read ports. Address 0 always returns zero. While reset is high both
    // ports return zero and the bypass path is suppressed. With BYPASS set, a
    // write in the same cycle to the addressed entry is forwarded.
    always_comb begin
        RD1 = '0;
        if (!reset && (A1 != '0)) begin
            if (BYPASS_EN && write_en && (WriteRegW == A1)) begin
                RD1 = ResultW;
            end else begin
                RD1 = regs_q[A1];
            end
        end
    end

    always_comb begin
        RD2 = '0;
        if (!reset && (A2 != '0)) begin
            if (BYPASS_EN && write_en && (WriteRegW == A2)) begin
                RD2 = ResultW;
            end else begin
                RD2 = regs_q[A2];
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile
//   Directed bench for wb_regfile. Two instances share every input: dut has
//   BYPASS=1 and dut_nb has BYPASS=0. The expected values are constants
//   worked out by hand from the register-file behaviour. Inputs change on the
//   falling edge. Outputs are checked 1ns after a falling or rising edge.
// ----------------------------------------------------------------------------
module tb_wb_regfile;

    logic        ref_clk;
    logic        reset;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] rd_in;
    logic [31:0] alu_in;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1, RD2, ResultW;
    logic [31:0] nb_RD1, nb_RD2, nb_ResultW;

    int total;
    int bad;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .BYPASS(1)) dut (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .rd_in     (rd_in),
        .alu_in    (alu_in),
        .WriteRegW (WriteRegW),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .ResultW   (ResultW)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .BYPASS(0)) dut_nb (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .rd_in     (rd_in),
        .alu_in    (alu_in),
        .WriteRegW (WriteRegW),
        .A1        (A1),
        .A2        (A2),
        .RD1       (nb_RD1),
        .RD2       (nb_RD2),
        .ResultW   (nb_ResultW)
    );

    // Clock generation
    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for the next falling edge (the input drive point), then settle 1ns.
    task automatic at_negedge();
        @(negedge ref_clk);
        #1;
    endtask

    // Let the next rising edge happen, then sample 1ns later.
    task automatic past_posedge();
        @(posedge ref_clk);
        #1;
    endtask

    // Drive a write that commits on the next rising edge. The enable is
    // dropped again at the following falling edge.
    task automatic do_write(input logic [4:0] addr, input logic mem, input logic [31:0] rdv,
                            input logic [31:0] aluv);
        @(negedge ref_clk);
        RegWriteW = 1'b1;
        MemtoRegW = mem;
        rd_in     = rdv;
        alu_in    = aluv;
        WriteRegW = addr;
        @(negedge ref_clk);
        RegWriteW = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset     = 1'b1;
        RegWriteW = 1'b0;
        MemtoRegW = 1'b0;
        rd_in     = '0;
        alu_in    = '0;
        WriteRegW = '0;
        A1        = 5'd5;
        A2        = 5'd31;

        // Power-on reset
        #1;
        check("por_rd1", RD1, 32'h0);
        check("por_rd2", RD2, 32'h0);
        repeat (2) @(negedge ref_clk);
        reset = 1'b0;
        #1;
        check("por_rel_rd1", RD1, 32'h0);
        check("por_rel_rd2", RD2, 32'h0);

        // ALU write to r2
        RegWriteW = 1'b1;
        MemtoRegW = 1'b0;
        rd_in     = 32'h0000_0055;
        alu_in    = 32'h0000_0003;
        WriteRegW = 5'd2;
        A1        = 5'd0;
        #1;
        check("alu_resultw_pre", ResultW, 32'h3);
        past_posedge();
        @(negedge ref_clk);
        RegWriteW = 1'b0;
        A1        = 5'd2;
        #1;
        check("alu_rd1", RD1, 32'h3);
        check("alu_rd1_nb", nb_RD1, 32'h3);

        // Load write to r3
        RegWriteW = 1'b1;
        MemtoRegW = 1'b1;
        rd_in     = 32'h0000_00F8;
        alu_in    = 32'h0000_0700;
        WriteRegW = 5'd3;
        #1;
        check("load_resultw", ResultW, 32'hF8);
        past_posedge();
        @(negedge ref_clk);
        RegWriteW = 1'b0;
        A2        = 5'd3;
        #1;
        check("load_rd2", RD2, 32'hF8);
        A1 = 5'd3;
        #1;
        check("same_addr_rd1", RD1, 32'hF8);
        check("same_addr_rd2", RD2, 32'hF8);

        // r0 protection
        @(negedge ref_clk);
        RegWriteW = 1'b1;
        MemtoRegW = 1'b0;
        alu_in    = 32'hDEAD_BEEF;
        WriteRegW = 5'd0;
        A1        = 5'd0;
        A2        = 5'd0;
        #1;
        check("r0_pre_rd1", RD1, 32'h0);
        check("r0_pre_rd2", RD2, 32'h0);
        past_posedge();
        @(negedge ref_clk);
        RegWriteW = 1'b0;
        #1;
        check("r0_post_rd1", RD1, 32'h0);
        A1 = 5'd2;
        A2 = 5'd3;
        #1;
        check("r0_r2_kept", RD1, 32'h3);
        check("r0_r3_kept", RD2, 32'hF8);

        // Bypass: r6 holds 1, then a same-cycle write of 0xF
        do_write(5'd6, 1'b0, 32'h0, 32'h1);
        RegWriteW = 1'b1;
        MemtoRegW = 1'b0;
        alu_in    = 32'hF;
        WriteRegW = 5'd6;
        A1        = 5'd6;
        A2        = 5'd6;
        #1;
        check("byp_pre_rd1", RD1, 32'hF);
        check("byp_pre_rd2", RD2, 32'hF);
        check("nobyp_pre_rd1", nb_RD1, 32'h1);
        check("nobyp_pre_rd2", nb_RD2, 32'h1);
        past_posedge();
        check("byp_post_rd1", RD1, 32'hF);
        check("nobyp_post_rd1", nb_RD1, 32'hF);
        @(negedge ref_clk);
        RegWriteW = 1'b0;
        #1;
        check("byp_held_rd1", RD1, 32'hF);

        // Write disabled: r1 holds 0x11, then a disabled write of 2
        do_write(5'd1, 1'b0, 32'h0, 32'h11);
        RegWriteW = 1'b0;
        MemtoRegW = 1'b0;
        alu_in    = 32'h2;
        WriteRegW = 5'd1;
        A1        = 5'd1;
        #1;
        check("wdis_resultw", ResultW, 32'h2);
        check("wdis_pre_rd1", RD1, 32'h11);
        past_posedge();
        at_negedge();
        check("wdis_post_rd1", RD1, 32'h11);
        check("wdis_post_rd1_nb", nb_RD1, 32'h11);

        // Mid-run reset with a write pending to r7
        RegWriteW = 1'b1;
        MemtoRegW = 1'b0;
        alu_in    = 32'h77;
        WriteRegW = 5'd7;
        A1        = 5'd7;
        A2        = 5'd2;
        #1;
        check("pend_byp_rd1", RD1, 32'h77);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_rd1", RD1, 32'h0);
        check("rst_async_rd2", RD2, 32'h0);
        check("rst_resultw", ResultW, 32'h77);
        past_posedge();
        check("rst_edge_rd1", RD1, 32'h0);
        A1 = 5'd6;
        A2 = 5'd3;
        #1;
        check("rst_r6_rd1", RD1, 32'h0);
        check("rst_r3_rd2", RD2, 32'h0);
        @(negedge ref_clk);
        RegWriteW = 1'b0;
        reset     = 1'b0;
        for (int a = 1; a < 32; a++) begin
            A1 = a[4:0];
            A2 = a[4:0];
            #1;
            check($sformatf("rst_clear_rd1_r%0d", a), RD1, 32'h0);
            check($sformatf("rst_clear_rd2_r%0d", a), nb_RD2, 32'h0);
        end

        // First write after reset release
        do_write(5'd9, 1'b1, 32'h99, 32'h123);
        A1 = 5'd9;
        A2 = 5'd7;
        #1;
        check("post_rst_r9", RD1, 32'h99);
        check("post_rst_r7_lost", RD2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
